// File: rtl/vote_result_reader.sv
// Snapshots candidate counts and voter status on start, streams eight records
// over valid/ready, and publishes winner/tie/turnout/audit results at the end.
module vote_result_reader #(
    parameter int NUM_CAND  = 3,
    parameter int NUM_VOTER = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] cand_counts,
    input  logic [15:0] voter_status,
    input  logic        rec_ready,
    output logic        rec_valid,
    output logic [1:0]  rec_kind,
    output logic [1:0]  rec_index,
    output logic [5:0]  rec_value,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic        winner_valid,
    output logic        tie,
    output logic [2:0]  turnout,
    output logic        audit_err
);

    // state | meaning
    // IDLE  | waiting for start
    // CAND  | presenting candidate record idx
    // VOTER | presenting voter record idx
    // SUMM  | presenting summary (total votes)
    // FIN   | one-cycle done pulse
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CAND  = 3'd1;
    localparam logic [2:0] S_VOTER = 3'd2;
    localparam logic [2:0] S_SUMM  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [1:0] LAST_CAND  = 2'(NUM_CAND - 1);
    localparam logic [1:0] LAST_VOTER = 2'(NUM_VOTER - 1);

    logic [2:0]  state;
    logic [1:0]  idx;
    logic [11:0] cand_snap;
    logic [15:0] voter_snap;
    logic [5:0]  total_acc;
    logic [3:0]  max_acc;
    logic [1:0]  win_acc;
    logic        tie_acc;
    logic [2:0]  turn_acc;
    logic [3:0]  cur_cand;
    logic [3:0]  cur_voter;
    logic        accept;

    assign cur_cand  = cand_snap[{idx, 2'b00} +: 4];
    assign cur_voter = voter_snap[{idx, 2'b00} +: 4];
    assign accept    = rec_valid & rec_ready;

    // Record outputs decode straight from flops, so they change only on clock edges.
    always_comb begin
        rec_valid = 1'b0;
        rec_kind  = 2'b00;
        rec_index = 2'b00;
        rec_value = 6'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_CAND: begin
                rec_valid = 1'b1;
                rec_index = idx;
                rec_value = {2'b00, cur_cand};
                busy      = 1'b1;
            end
            S_VOTER: begin
                rec_valid = 1'b1;
                rec_kind  = 2'b01;
                rec_index = idx;
                rec_value = {2'b00, cur_voter};
                busy      = 1'b1;
            end
            S_SUMM: begin
                rec_valid = 1'b1;
                rec_kind  = 2'b10;
                rec_value = total_acc;
                busy      = 1'b1;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= 2'd0;
            cand_snap    <= 12'd0;
            voter_snap   <= 16'd0;
            total_acc    <= 6'd0;
            max_acc      <= 4'd0;
            win_acc      <= 2'd0;
            tie_acc      <= 1'b0;
            turn_acc     <= 3'd0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
            turnout      <= 3'd0;
            audit_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cand_snap  <= cand_counts;
                    voter_snap <= voter_status;
                    total_acc  <= 6'd0;
                    max_acc    <= 4'd0;
                    win_acc    <= 2'd0;
                    tie_acc    <= 1'b0;
                    turn_acc   <= 3'd0;
                    idx        <= 2'd0;
                    state      <= S_CAND;
                end
                S_CAND: if (accept) begin
                    total_acc <= total_acc + {2'b00, cur_cand};
                    // Strict compare keeps the lowest index on equal maxima.
                    if (cur_cand > max_acc) begin
                        max_acc <= cur_cand;
                        win_acc <= idx;
                        tie_acc <= 1'b0;
                    end else if (cur_cand == max_acc && max_acc != 4'd0) begin
                        tie_acc <= 1'b1;
                    end
                    if (idx == LAST_CAND) begin
                        idx   <= 2'd0;
                        state <= S_VOTER;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                S_VOTER: if (accept) begin
                    turn_acc <= turn_acc + {2'b00, (cur_voter != 4'd0)};
                    if (idx == LAST_VOTER) begin
                        idx   <= 2'd0;
                        state <= S_SUMM;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                S_SUMM: if (accept) begin
                    winner       <= win_acc;
                    winner_valid <= (total_acc != 6'd0);
                    tie          <= tie_acc;
                    turnout      <= turn_acc;
                    audit_err    <= (total_acc != {3'b000, turn_acc});
                    state        <= S_FIN;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
